// File: rtl/prio_encoder_hs_if.sv
// Valid/ready bundle for prio_encoder_hs: request channel in, encoded-index channel out.
// The slave modport is the encoder's view; the master modport is the source/sink side.
interface prio_encoder_hs_if #(
    parameter int N = 8,
    parameter int W = $clog2(N)
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_req;
    logic         onehot_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_zero;
    logic         out_err;

    modport slave (
        input  in_valid,
        input  in_req,
        input  onehot_mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_idx,
        output out_zero,
        output out_err
    );

    modport master (
        output in_valid,
        output in_req,
        output onehot_mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_idx,
        input  out_zero,
        input  out_err
    );
endinterface

// File: rtl/prio_encoder_hs.sv
// Registered N-to-log2(N) encoder behind a one-deep valid/ready stage, with
// one-hot checking, zero detection and a saturating error counter.
module prio_encoder_hs #(
    parameter int N         = 8,
    parameter int W         = $clog2(N),
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    prio_encoder_hs_if.slave      bus,
    output logic [7:0]            err_cnt,
    input  logic                  clr_err
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic [W-1:0] idx;
        logic         zero;
        logic         err;
    } enc_t;

    state_e       state_r;
    state_e       state_nxt_s;
    logic         rdy_en_r;
    logic         accept_s;
    logic         transfer_s;
    enc_t         enc_s;
    enc_t         res_r;
    logic [7:0]   err_cnt_r;

    // Highest and lowest set indices are both tracked; one-hot mode uses the
    // highest, which is the only set bit whenever no error is flagged.
    function automatic enc_t encode(input logic [N-1:0] req, input logic onehot);
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         any;
        logic         multi;
        enc_t         r;
        hi    = '0;
        lo    = '0;
        any   = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            multi = multi | (any & req[i]);
            any   = any | req[i];
            hi    = req[i] ? W'(i) : hi;
        end
        for (int i = N - 1; i >= 0; i--) begin
            lo = req[i] ? W'(i) : lo;
        end
        r.zero = ~any;
        r.err  = onehot & multi;
        if (!any || r.err) begin
            r.idx = '0;
        end else if (onehot || !LSB_FIRST) begin
            r.idx = hi;
        end else begin
            r.idx = lo;
        end
        return r;
    endfunction

    assign accept_s      = bus.in_valid & bus.in_ready;
    assign transfer_s    = bus.out_valid & bus.out_ready;
    assign bus.in_ready  = rdy_en_r & ((state_r == EMPTY) | bus.out_ready);
    assign bus.out_valid = (state_r == FULL);
    assign bus.out_idx   = res_r.idx;
    assign bus.out_zero  = res_r.zero;
    assign bus.out_err   = res_r.err;
    assign err_cnt       = err_cnt_r;

    // Combinational encode of the presented request vector
    always_comb begin
        enc_s = encode(bus.in_req, bus.onehot_mode);
    end

    // Next-state logic for the one-deep output stage
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            EMPTY: begin
                if (accept_s) begin
                    state_nxt_s = FULL;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            FULL: begin
                if (transfer_s && !accept_s) begin
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: state_nxt_s = EMPTY;
        endcase
    end

    // State register; rdy_en_r keeps in_ready low until the first edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= EMPTY;
            rdy_en_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            rdy_en_r <= 1'b1;
        end
    end

    // Result register, loaded on every accept and held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_r <= '0;
        end else if (accept_s) begin
            res_r <= enc_s;
        end else begin
            res_r <= res_r;
        end
    end

    // Saturating error counter; clear takes precedence over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= 8'd0;
        end else if (clr_err) begin
            err_cnt_r <= 8'd0;
        end else if (accept_s && enc_s.err && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

endmodule

// File: tb/tb_prio_encoder_hs.sv
// Scoreboard bench: two N=8 encoders (highest-first and lowest-first) share
// stimulus; expected results are queued at accept and popped on transfer.
module tb_prio_encoder_hs;

    typedef struct {
        int idx;
        bit zero;
        bit err;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    int   checks;
    int   errors;
    int   exp_cnt;
    bit   rdy_live;
    exp_t q0[$];
    exp_t q1[$];

    prio_encoder_hs_if #(.N(8)) b0 ();
    prio_encoder_hs_if #(.N(8)) b1 ();

    prio_encoder_hs #(.N(8), .LSB_FIRST(1'b0)) dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (b0),
        .err_cnt (cnt0),
        .clr_err (clr)
    );

    prio_encoder_hs #(.N(8), .LSB_FIRST(1'b1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (b1),
        .err_cnt (cnt1),
        .clr_err (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: count set bits, then find extreme positions by shifting
    function automatic exp_t ref_enc(input logic [7:0] req, input bit oh, input bit lsb);
        exp_t       e;
        int         n;
        int         pos;
        logic [7:0] v;
        n      = $countones(req);
        e.zero = (n == 0);
        e.err  = oh && (n > 1);
        e.idx  = 0;
        if (n > 0 && !e.err) begin
            v   = req;
            pos = 0;
            if (lsb && !oh) begin
                while (v[0] == 1'b0) begin
                    v = v >> 1;
                    pos++;
                end
            end else begin
                while (v > 8'd1) begin
                    v = v >> 1;
                    pos++;
                end
            end
            e.idx = pos;
        end
        return e;
    endfunction

    task automatic drive(input logic v, input logic [7:0] r, input logic oh, input logic ordy);
        b0.in_valid = v;  b0.in_req = r;  b0.onehot_mode = oh;  b0.out_ready = ordy;
        b1.in_valid = v;  b1.in_req = r;  b1.onehot_mode = oh;  b1.out_ready = ordy;
    endtask

    // One clock of stimulus: drive at negedge, predict handshake, commit at posedge
    task automatic step(input logic v, input logic [7:0] r, input logic oh,
                        input logic ordy, input logic c);
        bit   full;
        bit   rdy;
        bit   acc;
        int   nxt;
        exp_t e0;
        exp_t e1;
        @(negedge clk);
        drive(v, r, oh, ordy);
        clr = c;
        #1;
        full = (q0.size() > 0);
        rdy  = rdy_live && (!full || ordy);
        chk("in_ready0", int'(b0.in_ready), int'(rdy));
        chk("in_ready1", int'(b1.in_ready), int'(rdy));
        chk("out_valid0", int'(b0.out_valid), int'(full));
        chk("out_valid1", int'(b1.out_valid), int'(full));
        acc = v && rdy;
        e0  = ref_enc(r, oh, 1'b0);
        e1  = ref_enc(r, oh, 1'b1);
        if (acc) begin
            q0.push_back(e0);
            q1.push_back(e1);
        end
        nxt = exp_cnt;
        if (c) nxt = 0;
        else if (acc && e0.err && exp_cnt < 255) nxt = exp_cnt + 1;
        @(posedge clk);
        exp_cnt  = nxt;
        rdy_live = 1'b1;
    endtask

    task automatic pop_cmp(input int d, input int idx, input bit zero, input bit err);
        exp_t e;
        checks++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_out dut%0d actual=valid required=none", d);
        end else begin
            checks--;
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("out_idx%0d", d), idx, e.idx);
            chk($sformatf("out_zero%0d", d), int'(zero), int'(e.zero));
            chk($sformatf("out_err%0d", d), int'(err), int'(e.err));
        end
    endtask

    // Monitor: pops the scoreboard whenever a transfer is pending this cycle
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (b0.out_valid && b0.out_ready) pop_cmp(0, int'(b0.out_idx), b0.out_zero, b0.out_err);
            if (b1.out_valid && b1.out_ready) pop_cmp(1, int'(b1.out_idx), b1.out_zero, b1.out_err);
            chk("err_cnt0", int'(cnt0), exp_cnt);
            chk("err_cnt1", int'(cnt1), exp_cnt);
        end
    end

    task automatic check_reset_state();
        chk("rst_out_valid", int'(b0.out_valid), 0);
        chk("rst_in_ready", int'(b0.in_ready), 0);
        chk("rst_out_idx", int'(b0.out_idx), 0);
        chk("rst_out_zero", int'(b0.out_zero), 0);
        chk("rst_out_err", int'(b0.out_err), 0);
        chk("rst_err_cnt", int'(cnt0), 0);
        chk("rst_err_cnt1", int'(cnt1), 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_release", int'(b0.in_ready), 0);
        @(posedge clk);
        rdy_live = 1'b1;
    endtask

    initial begin
        logic [7:0] r;
        int         k;
        checks   = 0;
        errors   = 0;
        exp_cnt  = 0;
        rdy_live = 1'b0;
        clr      = 1'b0;
        rst_n    = 1'b0;
        drive(1'b0, 8'd0, 1'b0, 1'b0);
        #12;
        check_reset_state();
        release_reset();

        // Single-bit priority, two-bit vector in every mode, zero in both modes
        step(1'b1, 8'b0000_0100, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'b0001_0010, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'b0001_0010, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'h80, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Backpressure, then drain-and-refill in the same cycle
        step(1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h81, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Saturation of the error counter, then clear racing an increment
        for (int i = 0; i < 260; i++) step(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
        chk("err_cnt_sat", int'(cnt0), 255);
        step(1'b1, 8'h11, 1'b1, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Random traffic with mixed backpressure, sparse vectors and rare clears
        for (int i = 0; i < 400; i++) begin
            k = int'($urandom_range(0, 3));
            if (k == 0)      r = 8'd0;
            else if (k == 1) r = 8'd1 << $urandom_range(0, 7);
            else             r = 8'($urandom);
            step(1'($urandom), r, 1'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 31) == 0));
        end

        // Asynchronous reset while a result is held
        step(1'b1, 8'h06, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state();
        q0.delete();
        q1.delete();
        exp_cnt  = 0;
        rdy_live = 1'b0;
        drive(1'b0, 8'd0, 1'b0, 1'b1);
        release_reset();
        step(1'b1, 8'h20, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        #3;
        chk("drained0", q0.size(), 0);
        chk("drained1", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
